// File: rtl/game_event_arbiter_pkg.sv
// Shared types for the game event arbiter: object classes, game states and the
// one-hot class mask helper.
package game_pkg;

   typedef enum logic [1:0] {
      SOLID  = 2'd0,
      HAZARD = 2'd1,
      PICKUP = 2'd2,
      EXIT   = 2'd3
   } obj_class_t;

   typedef enum logic [2:0] {
      PLAY,
      INVULN,
      LEVEL_DONE,
      GAME_OVER,
      WON
   } game_state_t;

   localparam int CLASS_MASK_W = 4;

   function automatic logic [CLASS_MASK_W-1:0] class_bit(input obj_class_t c);
      return CLASS_MASK_W'(1) << c;
   endfunction

endpackage

// File: rtl/game_event_arbiter_frame_class_accum.sv
// Per-frame sticky class mask and first-hit flag; presents the resolved mask
// (stored plus same-cycle hits) for use on the startOfFrame cycle.
module frame_class_accum
   import game_pkg::*;
#(
   parameter int                   NUM_OBJ   = 8,
   parameter logic [2*NUM_OBJ-1:0] OBJ_CLASS = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_active,
   input  logic                    i_sof,
   input  logic                    i_clear,
   input  logic                    i_time_up,
   input  logic [NUM_OBJ-1:0]      i_coll,
   output logic [CLASS_MASK_W-1:0] o_mask,
   output logic                    o_hit_pulse
);

   logic [CLASS_MASK_W-1:0] w_cur;
   logic [CLASS_MASK_W-1:0] r_mask;
   logic                    w_any;
   logic                    r_hit;
   logic                    r_hit_pulse;

   always_comb begin
      w_cur = '0;
      if (i_active) begin
         for (int i = 0; i < NUM_OBJ; i++)
            if (i_coll[i]) w_cur = w_cur | class_bit(obj_class_t'(OBJ_CLASS[2*i +: 2]));
         if (i_time_up) w_cur = w_cur | class_bit(HAZARD);
      end
   end

   assign w_any       = i_active & (|i_coll);
   assign o_mask      = r_mask | w_cur;
   assign o_hit_pulse = r_hit_pulse;

   // A hit on the startOfFrame cycle belongs to the closing frame.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_mask      <= '0;
         r_hit       <= 1'b0;
         r_hit_pulse <= 1'b0;
      end else begin
         r_hit_pulse <= w_any & ~r_hit;
         if (i_sof) begin
            r_mask <= '0;
            r_hit  <= 1'b0;
         end else begin
            r_mask <= o_mask;
            r_hit  <= r_hit | w_any;
         end
      end
   end

endmodule

// File: rtl/game_event_arbiter.sv
// Per-frame collision arbiter and game-state controller: resolves the frame
// class mask at startOfFrame and drives lives, score and level.
module game_event_arbiter
   import game_pkg::*;
#(
   parameter int                   NUM_OBJ           = 8,
   parameter logic [2*NUM_OBJ-1:0] OBJ_CLASS         = '0,
   parameter int                   INIT_LIVES        = 3,
   parameter int                   LIVES_W           = 4,
   parameter int                   SCORE_W           = 16,
   parameter int                   PICKUP_POINTS     = 10,
   parameter int                   INVULN_FRAMES     = 30,
   parameter int                   LEVEL_HOLD_FRAMES = 15,
   parameter int                   MAX_LEVEL         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               drawR_player,
   input  logic [NUM_OBJ-1:0] drawR_obj,
   input  logic               timeUp,
   input  logic               restart,
   output logic [NUM_OBJ-1:0] collision,
   output logic               SingleHitPulse,
   output logic               decreaseLife,
   output logic               raiseScore,
   output logic               nextLevel,
   output logic               gameOn,
   output logic               gameWon,
   output logic               timerEnable,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         level
);

   localparam int FRM_MAX = (INVULN_FRAMES > LEVEL_HOLD_FRAMES) ? INVULN_FRAMES : LEVEL_HOLD_FRAMES;
   localparam int FRM_W   = (FRM_MAX < 2) ? 1 : $clog2(FRM_MAX + 1);

   game_state_t             r_state, w_next;
   logic [CLASS_MASK_W-1:0] w_mask;
   logic [LIVES_W-1:0]      r_lives;
   logic [SCORE_W-1:0]      r_score;
   logic [SCORE_W:0]        w_score_sum;
   logic [2:0]              r_level;
   logic [FRM_W-1:0]        r_frames;
   logic                    w_active, w_restart, w_exit, w_haz, w_pick, w_last, w_frame_end;
   logic                    r_dl, r_rs, r_nl;

   assign collision = {NUM_OBJ{drawR_player}} & drawR_obj;

   assign w_active  = (r_state == PLAY) || (r_state == INVULN);
   assign w_restart = restart && ((r_state == GAME_OVER) || (r_state == WON));

   frame_class_accum #(
      .NUM_OBJ   (NUM_OBJ),
      .OBJ_CLASS (OBJ_CLASS)
   ) u_accum (
      .clk         (clk),
      .reset       (reset),
      .i_active    (w_active),
      .i_sof       (startOfFrame),
      .i_clear     (w_restart),
      .i_time_up   (timeUp),
      .i_coll      (collision),
      .o_mask      (w_mask),
      .o_hit_pulse (SingleHitPulse)
   );

   // EXIT masks HAZARD; PICKUP scores regardless of the other two.
   assign w_exit      = startOfFrame && w_active && (|(w_mask & class_bit(EXIT)));
   assign w_haz       = startOfFrame && (r_state == PLAY) && (|(w_mask & class_bit(HAZARD)))
                        && !(|(w_mask & class_bit(EXIT)));
   assign w_pick      = startOfFrame && w_active && (|(w_mask & class_bit(PICKUP)));
   assign w_last      = (r_level == 3'(MAX_LEVEL));
   assign w_frame_end = startOfFrame && (r_frames <= FRM_W'(1));
   assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(PICKUP_POINTS);

   always_ff @(posedge clk) begin
      if (reset) r_state <= PLAY;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         PLAY: begin
            if (w_exit)     w_next = w_last ? WON : LEVEL_DONE;
            else if (w_haz) w_next = (r_lives <= LIVES_W'(1)) ? GAME_OVER : INVULN;
         end
         INVULN: begin
            if (w_exit)           w_next = w_last ? WON : LEVEL_DONE;
            else if (w_frame_end) w_next = PLAY;
         end
         LEVEL_DONE:    if (w_frame_end) w_next = PLAY;
         GAME_OVER, WON: if (restart)    w_next = PLAY;
         default:       w_next = PLAY;
      endcase
   end

   always_comb begin
      gameOn      = 1'b0;
      gameWon     = 1'b0;
      timerEnable = 1'b0;
      case (r_state)
         PLAY, INVULN: begin
            gameOn      = 1'b1;
            timerEnable = 1'b1;
         end
         LEVEL_DONE: gameOn  = 1'b1;
         WON:        gameWon = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || w_restart) begin
         r_lives  <= LIVES_W'(INIT_LIVES);
         r_score  <= '0;
         r_level  <= '0;
         r_frames <= '0;
         r_dl     <= 1'b0;
         r_rs     <= 1'b0;
         r_nl     <= 1'b0;
      end else begin
         r_dl <= w_haz;
         r_rs <= w_pick;
         r_nl <= w_exit && !w_last;
         if (w_haz && (r_lives != '0)) r_lives <= r_lives - LIVES_W'(1);
         if (w_pick) r_score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
         if (w_haz && (w_next == INVULN))
            r_frames <= FRM_W'(INVULN_FRAMES);
         else if (w_exit && (w_next == LEVEL_DONE))
            r_frames <= FRM_W'(LEVEL_HOLD_FRAMES);
         else if (startOfFrame && (r_frames != '0) && ((r_state == INVULN) || (r_state == LEVEL_DONE)))
            r_frames <= r_frames - FRM_W'(1);
         if ((r_state == LEVEL_DONE) && w_frame_end) r_level <= r_level + 3'd1;
      end
   end

   assign decreaseLife = r_dl;
   assign raiseScore   = r_rs;
   assign nextLevel    = r_nl;
   assign lives        = r_lives;
   assign score        = r_score;
   assign level        = r_level;

endmodule

// File: doc/game_event_arbiter.md
Name: game_event_arbiter

Overview:
- Parametrised per-frame collision arbiter and game-state controller for N drawing-request channels against the player sprite.
- Each channel is tagged with a class: SOLID, HAZARD, PICKUP or EXIT.
- Collisions are accumulated over a frame, resolved once at the next startOfFrame, and drive internal lives, score and level counters through a play/invulnerable/level-done/game-over FSM.
- Sits between the object drawers and the score/lives display and timer blocks.

Parameters:
NUM_OBJ, 8, number of object drawR channels
OBJ_CLASS, all SOLID, NUM_OBJ x 2-bit class per channel (pkg enum obj_class_t)
INIT_LIVES, 3, lives loaded on reset/restart
LIVES_W, 4, lives counter width
SCORE_W, 16, score counter width (saturating)
PICKUP_POINTS, 10, score added per PICKUP frame
INVULN_FRAMES, 30, frames hazards are ignored after a life loss
LEVEL_HOLD_FRAMES, 15, frames held in LEVEL_DONE before next level
MAX_LEVEL, 4, last level index; EXIT on it ends game as won

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
drawR_player  in  1  player pixel request
drawR_obj  in  NUM_OBJ  object pixel requests
timeUp  in  1  level timer expired (level-sensitive; treated as HAZARD)
restart  in  1  pulse; leaves GAME_OVER/WON
collision  out  NUM_OBJ  drawR_player & drawR_obj[i], combinational
SingleHitPulse  out  1  first collision pixel of a frame, 1 cycle
decreaseLife  out  1  1-cycle pulse
raiseScore  out  1  1-cycle pulse
nextLevel  out  1  1-cycle pulse
gameOn  out  1  state is PLAY, INVULN or LEVEL_DONE
gameWon  out  1  state is WON
timerEnable  out  1  state is PLAY or INVULN
lives  out  LIVES_W  remaining lives
score  out  SCORE_W  current score
level  out  3  current level, 0-based

Behaviour:
- Reset (sync, active-high): state=PLAY, lives=INIT_LIVES, score=0, level=0, frame class mask=0, hit flag=0. All pulse outputs 0. gameOn=1, timerEnable=1, gameWon=0.
- Accumulation (PLAY/INVULN only): each cycle, OR the class of every asserted collision[i] into a 4-bit sticky mask; timeUp sets the HAZARD bit.
- SingleHitPulse: asserts one cycle after the first cycle in a frame with any collision (registered). It asserts at most once per frame.
- startOfFrame cycle: the current mask, including any same-cycle hits, is resolved; the mask and hit flag are cleared in that same cycle. The resolution pulses are registered and appear the cycle after startOfFrame.
- Resolution priority is EXIT > HAZARD; PICKUP is independent of both.
  - EXIT in PLAY/INVULN: nextLevel=1 and state goes to LEVEL_DONE. Any HAZARD in the same frame is ignored. If level==MAX_LEVEL, state goes to WON instead and no nextLevel pulse is issued.
  - HAZARD in PLAY: decreaseLife=1 and lives decrements. If lives was 1, lives becomes 0 and state goes to GAME_OVER; otherwise state goes to INVULN with the frame counter loaded to INVULN_FRAMES.
  - HAZARD in INVULN: ignored.
  - PICKUP: raiseScore=1 and score += PICKUP_POINTS, saturating at 2^SCORE_W-1. This also applies in the same frame as HAZARD or EXIT.
  - SOLID: contributes to SingleHitPulse only.
- INVULN: the frame counter decrements on each startOfFrame; at 0, state returns to PLAY.
- LEVEL_DONE: counts LEVEL_HOLD_FRAMES frames, then level increments and state returns to PLAY. Collisions are not accumulated in this state.
- GAME_OVER / WON: counters freeze. restart reloads the reset values except state→PLAY; restart is ignored in other states.
- Simultaneous restart and startOfFrame: restart wins and the mask is cleared.
- Reset mid-frame discards the partial mask.

Decomposition:
- Package game_pkg:
  - obj_class_t enum: SOLID=0, HAZARD=1, PICKUP=2, EXIT=3
  - game_state_t enum: PLAY, INVULN, LEVEL_DONE, GAME_OVER, WON
  - CLASS_MASK_W=4
- Natural sub-module: frame_class_accum. It holds the per-channel class decode, the sticky mask and the first-hit flag, and emits the resolved mask at startOfFrame.
- The FSM and counters stay in the top level.

Test Plan:
- HAZARD on channel 2, INIT_LIVES=3, PLAY; drive 5 collision cycles in one frame -> exactly one SingleHitPulse. At the next startOfFrame: one decreaseLife, lives=2, state INVULN.
- Hazard collisions during the following 30 frames -> no decreaseLife. In frame 31 a hazard -> decreaseLife and lives=1.
- PICKUP and HAZARD in the same frame, score=0 -> raiseScore and decreaseLife on the same cycle, score=10.
- EXIT and HAZARD in the same frame at level 0 -> nextLevel only, lives unchanged. After 15 frames level=1 and timerEnable=1; no collisions accumulate during the hold.
- lives=1 with timeUp held -> GAME_OVER, gameOn=0, timerEnable=0. Pulse restart -> lives=3, score=0, level=0, state PLAY.
- SCORE_W=4, score=10, PICKUP -> score=15 (saturates). EXIT at level=MAX_LEVEL -> gameWon=1, no nextLevel pulse.
